// File: rtl/pixel_write_port.sv
// -----------------------------------------------------------------------------
// pixel_write_port
//
// Upstream feeder for the 200x150 VGA framebuffer.
//
// Host pixel writes arrive asynchronously: a strobe on an interrupt pin plus
// an address and a 3-bit {b,g,r} colour. Each write is synchronized into the
// clk_10mhz domain and range-checked. Surviving writes are buffered in a small
// FIFO. A registered output stage then presents them to the framebuffer write
// port with a valid/ready handshake.
//
// A clear_req pulse runs a full-screen clear. During the clear the output
// stage walks every address once with CLEAR_COLOR. Host writes captured
// meanwhile stay queued and drain afterwards, so they land on top of the
// cleared screen.
//
// Ports
//   clk_10mhz    in   1       pixel clock, everything on the rising edge
//   reset        in   1       synchronous, active-high
//   host_strobe  in   1       async write strobe, write on its rising edge
//   host_addr    in   ADDR_W  async pixel address
//   host_rgb     in   DATA_W  async pixel data {b,g,r}
//   clear_req    in   1       one-cycle pulse, starts the clear sequence
//   fb_wr_addr   out  ADDR_W  framebuffer write address
//   fb_wr_data   out  DATA_W  framebuffer write data
//   fb_wr_valid  out  1       write pending
//   fb_wr_ready  in   1       framebuffer accepts (transfer on valid&&ready)
//   busy         out  1       clear sequence in progress
//   overflow     out  1       sticky: host write dropped, FIFO full
//   range_err    out  1       sticky: host write dropped, addr >= PIXELS
// -----------------------------------------------------------------------------
module pixel_write_port #(
  parameter int                ADDR_W      = 15,
  parameter int                DATA_W      = 3,
  parameter int                PIXELS      = 30000,
  parameter int                FIFO_DEPTH  = 4,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] CLEAR_COLOR = '0
) (
  input  logic              clk_10mhz,
  input  logic              reset,
  input  logic              host_strobe,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_rgb,
  input  logic              clear_req,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [DATA_W-1:0] fb_wr_data,
  output logic              fb_wr_valid,
  input  logic              fb_wr_ready,
  output logic              busy,
  output logic              overflow,
  output logic              range_err
);

  localparam int                PTR_W     = $clog2(FIFO_DEPTH);
  localparam int                ENTRY_W   = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t state;
  state_t state_next;

  // ---------------------------------------------------------------------------
  // Pin synchronizers
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] strobe_sync;
  logic [ADDR_W-1:0]      addr_sync [SYNC_STAGES];
  logic [DATA_W-1:0]      rgb_sync  [SYNC_STAGES];
  logic                   strobe_prev;
  logic                   strobe_rise;

  // Address and data go through the same number of stages as the strobe.
  // The host holds them stable around the strobe edge, so the last stage is
  // settled when the strobe edge is seen.
  always_ff @(posedge clk_10mhz) begin
    if (reset) begin
      strobe_sync <= '0;
      strobe_prev <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        addr_sync[i] <= '0;
        rgb_sync[i]  <= '0;
      end
    end else begin
      strobe_sync  <= {strobe_sync[SYNC_STAGES-2:0], host_strobe};
      strobe_prev  <= strobe_sync[SYNC_STAGES-1];
      addr_sync[0] <= host_addr;
      rgb_sync[0]  <= host_rgb;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        addr_sync[i] <= addr_sync[i-1];
        rgb_sync[i]  <= rgb_sync[i-1];
      end
    end
  end

  assign strobe_rise = strobe_sync[SYNC_STAGES-1] & ~strobe_prev;

  // ---------------------------------------------------------------------------
  // Capture register: one cycle between edge detect and the FIFO push
  // ---------------------------------------------------------------------------
  logic              cap_valid;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_rgb;
  logic              cap_out_of_range;

  always_ff @(posedge clk_10mhz) begin
    if (reset) begin
      cap_valid <= 1'b0;
      cap_addr  <= '0;
      cap_rgb   <= '0;
    end else begin
      cap_valid <= strobe_rise;
      if (strobe_rise) begin
        cap_addr <= addr_sync[SYNC_STAGES-1];
        cap_rgb  <= rgb_sync[SYNC_STAGES-1];
      end
    end
  end

  assign cap_out_of_range = cap_addr > LAST_ADDR;

  // ---------------------------------------------------------------------------
  // Write FIFO
  // ---------------------------------------------------------------------------
  logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr;
  logic [PTR_W:0]     rd_ptr;
  logic [PTR_W:0]     fill;
  logic [PTR_W-1:0]   rd_idx;
  logic [PTR_W-1:0]   rd_next_idx;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_multi;
  logic               push;
  logic               pop;
  logic [ADDR_W-1:0]  head_addr;
  logic [DATA_W-1:0]  head_rgb;
  logic [ADDR_W-1:0]  next_addr;
  logic [DATA_W-1:0]  next_rgb;

  assign fill        = wr_ptr - rd_ptr;
  assign fifo_empty  = (fill == '0);
  assign fifo_full   = (fill == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_multi  = (fill > (PTR_W+1)'(1));
  assign rd_idx      = rd_ptr[PTR_W-1:0];
  assign rd_next_idx = rd_idx + PTR_W'(1);

  assign {head_addr, head_rgb} = fifo_mem[rd_idx];
  assign {next_addr, next_rgb} = fifo_mem[rd_next_idx];

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign push = cap_valid & ~cap_out_of_range & (~fifo_full | pop);

  always_ff @(posedge clk_10mhz) begin
    if (push) begin
      fifo_mem[wr_ptr[PTR_W-1:0]] <= {cap_addr, cap_rgb};
    end
  end

  always_ff @(posedge clk_10mhz) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_10mhz) begin
    if (reset) begin
      range_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (cap_valid && cap_out_of_range) begin
        range_err <= 1'b1;
      end
      if (cap_valid && !cap_out_of_range && fifo_full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Clear request capture
  // ---------------------------------------------------------------------------
  logic clear_pend;
  logic clear_take;
  logic out_xfer;
  logic at_last_addr;

  assign out_xfer     = fb_wr_valid & fb_wr_ready;
  assign at_last_addr = (fb_wr_addr == LAST_ADDR);

  // The clear can only start once the output stage is free. Until then the
  // request waits here. Requests during a clear are ignored.
  assign clear_take = (state == ST_IDLE) && (clear_req || clear_pend) &&
                      (!fb_wr_valid || fb_wr_ready);

  always_ff @(posedge clk_10mhz) begin
    if (reset) begin
      clear_pend <= 1'b0;
    end else if (clear_take) begin
      clear_pend <= 1'b0;
    end else if (state == ST_IDLE && clear_req) begin
      clear_pend <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_10mhz) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (clear_take) begin
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (out_xfer && at_last_addr) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and output-stage controls
  // ---------------------------------------------------------------------------
  logic clear_start;
  logic clear_step;
  logic load_head;
  logic load_next;
  logic drop_valid;

  // In IDLE the output register mirrors the FIFO head. The head is popped
  // only when the framebuffer takes it. At that point the entry behind it is
  // loaded in the same cycle, so back-to-back writes have no bubble.
  always_comb begin
    busy        = 1'b0;
    pop         = 1'b0;
    clear_start = 1'b0;
    clear_step  = 1'b0;
    load_head   = 1'b0;
    load_next   = 1'b0;
    drop_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        pop = out_xfer;
        if (clear_take) begin
          clear_start = 1'b1;
        end else if (out_xfer) begin
          if (fifo_multi) begin
            load_next = 1'b1;
          end else begin
            drop_valid = 1'b1;
          end
        end else if (!fb_wr_valid && !fifo_empty) begin
          load_head = 1'b1;
        end
      end
      ST_CLEAR: begin
        busy = 1'b1;
        // The FIFO head was never popped during the clear. It is still at
        // rd_ptr, so it reloads straight after the last clear pixel.
        if (out_xfer) begin
          if (at_last_addr) begin
            if (!fifo_empty) begin
              load_head = 1'b1;
            end else begin
              drop_valid = 1'b1;
            end
          end else begin
            clear_step = 1'b1;
          end
        end
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  // During a clear, fb_wr_addr itself is the clear counter.
  always_ff @(posedge clk_10mhz) begin
    if (reset) begin
      fb_wr_valid <= 1'b0;
      fb_wr_addr  <= '0;
      fb_wr_data  <= '0;
    end else if (clear_start) begin
      fb_wr_valid <= 1'b1;
      fb_wr_addr  <= '0;
      fb_wr_data  <= CLEAR_COLOR;
    end else if (clear_step) begin
      fb_wr_addr <= fb_wr_addr + ADDR_W'(1);
    end else if (load_head) begin
      fb_wr_valid <= 1'b1;
      fb_wr_addr  <= head_addr;
      fb_wr_data  <= head_rgb;
    end else if (load_next) begin
      fb_wr_valid <= 1'b1;
      fb_wr_addr  <= next_addr;
      fb_wr_data  <= next_rgb;
    end else if (drop_valid) begin
      fb_wr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pixel_write_port.sv
module tb_pixel_write_port;

  localparam int ADDR_W      = 15;
  localparam int DATA_W      = 3;
  localparam int PIXELS      = 30000;
  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 50;

  logic              clk_10mhz   = 1'b0;
  logic              reset       = 1'b1;
  logic              host_strobe = 1'b0;
  logic [ADDR_W-1:0] host_addr   = '0;
  logic [DATA_W-1:0] host_rgb    = '0;
  logic              clear_req   = 1'b0;
  logic              fb_wr_ready = 1'b0;
  logic [ADDR_W-1:0] fb_wr_addr;
  logic [DATA_W-1:0] fb_wr_data;
  logic              fb_wr_valid;
  logic              busy;
  logic              overflow;
  logic              range_err;

  pixel_write_port #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .PIXELS      (PIXELS),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES),
    .CLEAR_COLOR (3'b000)
  ) dut (
    .clk_10mhz   (clk_10mhz),
    .reset       (reset),
    .host_strobe (host_strobe),
    .host_addr   (host_addr),
    .host_rgb    (host_rgb),
    .clear_req   (clear_req),
    .fb_wr_addr  (fb_wr_addr),
    .fb_wr_data  (fb_wr_data),
    .fb_wr_valid (fb_wr_valid),
    .fb_wr_ready (fb_wr_ready),
    .busy        (busy),
    .overflow    (overflow),
    .range_err   (range_err)
  );

  always #HALF clk_10mhz = ~clk_10mhz;

  // Expected framebuffer transfers in order.
  typedef struct {
    int addr;
    int data;
    bit is_clear;
  } xfer_t;

  xfer_t exp_q[$];
  xfer_t cmp_e;

  int n_compared     = 0;
  int n_mismatched   = 0;
  int cyc            = 0;
  int strobe_e0      = 0;
  int first_valid    = 0;
  int valid_cycles   = 0;
  int busy_cycles    = 0;
  int xfer_count     = 0;
  int ready_mode     = 1;
  bit model_busy     = 1'b0;
  bit exp_overflow   = 1'b0;
  bit exp_range      = 1'b0;

  always @(posedge clk_10mhz) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Ready modes: 0 low, 1 high, 2 random with a guaranteed high every
  // 5th cycle, 3 toggling.
  initial begin
    forever begin
      @(posedge clk_10mhz);
      #5;
      case (ready_mode)
        0:       fb_wr_ready = 1'b0;
        1:       fb_wr_ready = 1'b1;
        2:       fb_wr_ready = ($urandom_range(0, 1) == 1) || (cyc % 5 == 0);
        default: fb_wr_ready = ~fb_wr_ready;
      endcase
    end
  end

  // Scoreboard: every transfer must be the next expected one.
  always @(negedge clk_10mhz) begin
    if (!reset) begin
      checkOutput("busy", 32'(busy), 32'(model_busy));
      if (busy) busy_cycles++;
      if (fb_wr_valid) begin
        valid_cycles++;
        if (first_valid == 0) first_valid = cyc;
      end
      if (fb_wr_valid && fb_wr_ready) begin
        xfer_count++;
        if (exp_q.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_xfer: got addr %0d data %0d, expected no transfer",
                   fb_wr_addr, fb_wr_data);
        end else begin
          cmp_e = exp_q.pop_front();
          checkOutput("xfer_addr", 32'(fb_wr_addr), 32'(cmp_e.addr));
          checkOutput("xfer_data", 32'(fb_wr_data), 32'(cmp_e.data));
          if (cmp_e.is_clear && cmp_e.addr == PIXELS - 1) model_busy = 1'b0;
        end
      end
    end
  end

  // One asynchronous host write: data settles a clock ahead of the strobe
  // and stays put well past the synchronizer window.
  task automatic applyStimulus(input int addr, input int rgb);
    @(posedge clk_10mhz);
    #13;
    host_addr = ADDR_W'(addr);
    host_rgb  = DATA_W'(rgb);
    @(posedge clk_10mhz);
    #13;
    host_strobe = 1'b1;
    strobe_e0   = cyc + 1;
    repeat (SYNC_STAGES + 3) @(posedge clk_10mhz);
    #13;
    host_strobe = 1'b0;
    repeat (SYNC_STAGES + 1) @(posedge clk_10mhz);
  endtask

  function automatic void modelWrite(input int addr, input int rgb);
    if (addr >= PIXELS) exp_range = 1'b1;
    else exp_q.push_back('{addr: addr, data: rgb, is_clear: 1'b0});
  endfunction

  task automatic waitDrain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk_10mhz);
      n++;
    end
    checkOutput(name, 32'(exp_q.size()), 32'd0);
    repeat (4) @(posedge clk_10mhz);
  endtask

  task automatic pulseClear();
    @(posedge clk_10mhz);
    #5;
    clear_req = 1'b1;
    @(posedge clk_10mhz);
    #5;
    clear_req = 1'b0;
    for (int a = 0; a < PIXELS; a++) exp_q.push_back('{addr: a, data: 0, is_clear: 1'b1});
    model_busy = 1'b1;
  endtask

  initial begin
    #(100 * 60000);
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int a;
    int r;
    int base;
    int lat;
    bit found;

    // Reset state
    repeat (3) @(posedge clk_10mhz);
    #1;
    checkOutput("rst_valid", 32'(fb_wr_valid), 32'd0);
    checkOutput("rst_addr", 32'(fb_wr_addr), 32'd0);
    checkOutput("rst_data", 32'(fb_wr_data), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_range_err", 32'(range_err), 32'd0);
    #4;
    reset = 1'b0;

    // Single write: latency and one-cycle valid
    ready_mode  = 1;
    first_valid = 0;
    valid_cycles = 0;
    repeat (2) @(posedge clk_10mhz);
    modelWrite(5, 3'b101);
    applyStimulus(5, 3'b101);
    repeat (8) @(posedge clk_10mhz);
    lat = first_valid - strobe_e0 + 1;
    $display("[TB] single write latency %0d clocks", lat);
    checkOutput("t1_seen", 32'(first_valid != 0), 32'd1);
    checkOutput("t1_latency_le_max", 32'(lat <= SYNC_STAGES + 3), 32'd1);
    checkOutput("t1_valid_cycles", 32'(valid_cycles), 32'd1);
    checkOutput("t1_drained", 32'(exp_q.size()), 32'd0);

    // Randomized writes under random backpressure
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) a = int'($urandom_range(PIXELS, 32767));
      else a = int'($urandom_range(0, PIXELS - 1));
      r = int'($urandom_range(0, 7));
      modelWrite(a, r);
      applyStimulus(a, r);
      repeat ($urandom_range(0, 3)) @(posedge clk_10mhz);
    end
    ready_mode = 1;
    waitDrain("rand_drain", 200);
    checkOutput("rand_range_err", 32'(range_err), 32'(exp_range));
    checkOutput("rand_overflow", 32'(overflow), 32'd0);

    // Stalled output: four held, two dropped
    ready_mode = 0;
    repeat (3) @(posedge clk_10mhz);
    for (int i = 0; i < 6; i++) begin
      if (i < FIFO_DEPTH) modelWrite(i, i + 1);
      else exp_overflow = 1'b1;
      applyStimulus(i, i + 1);
    end
    repeat (4) @(posedge clk_10mhz);
    @(negedge clk_10mhz);
    checkOutput("t2_held_valid", 32'(fb_wr_valid), 32'd1);
    checkOutput("t2_held_addr", 32'(fb_wr_addr), 32'd0);
    checkOutput("t2_overflow", 32'(overflow), 32'd1);
    ready_mode = 1;
    @(posedge clk_10mhz);
    #10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_10mhz);
      checkOutput("t2_consecutive_valid", 32'(fb_wr_valid), 32'd1);
    end
    @(negedge clk_10mhz);
    checkOutput("t2_after_valid", 32'(fb_wr_valid), 32'd0);
    waitDrain("t2_drain", 20);

    // Range boundary
    modelWrite(PIXELS, 3'b010);
    applyStimulus(PIXELS, 3'b010);
    modelWrite(PIXELS - 1, 3'b011);
    applyStimulus(PIXELS - 1, 3'b011);
    waitDrain("t3_drain", 20);
    checkOutput("t3_range_err", 32'(range_err), 32'd1);
    checkOutput("t3_overflow_sticky", 32'(overflow), 32'(exp_overflow));

    // Full clear with a host write landing mid-clear
    ready_mode  = 1;
    busy_cycles = 0;
    base        = xfer_count;
    pulseClear();
    repeat (500) @(posedge clk_10mhz);
    modelWrite(7, 3'b110);
    applyStimulus(7, 3'b110);
    waitDrain("t4_drain", 31000);
    checkOutput("t4_busy_cycles", 32'(busy_cycles), 32'd30000);
    checkOutput("t4_xfers", 32'(xfer_count - base), 32'd30001);
    checkOutput("t4_busy_low", 32'(busy), 32'd0);

    // Reset mid-clear with toggling ready and two queued writes
    ready_mode = 3;
    pulseClear();
    modelWrite(11, 3'b001);
    applyStimulus(11, 3'b001);
    modelWrite(22, 3'b010);
    applyStimulus(22, 3'b010);
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      @(negedge clk_10mhz);
      if (busy && fb_wr_addr == 100) found = 1'b1;
    end
    checkOutput("t6_reached_100", 32'(found), 32'd1);
    #1;
    reset = 1'b1;
    @(posedge clk_10mhz);
    #1;
    exp_q.delete();
    model_busy   = 1'b0;
    exp_overflow = 1'b0;
    exp_range    = 1'b0;
    checkOutput("t6_valid", 32'(fb_wr_valid), 32'd0);
    checkOutput("t6_addr", 32'(fb_wr_addr), 32'd0);
    checkOutput("t6_data", 32'(fb_wr_data), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_overflow", 32'(overflow), 32'd0);
    checkOutput("t6_range_err", 32'(range_err), 32'd0);
    #4;
    reset        = 1'b0;
    ready_mode   = 1;
    valid_cycles = 0;
    repeat (30) @(posedge clk_10mhz);
    checkOutput("t6_fifo_flushed", 32'(valid_cycles), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
